// File: rtl/cpu_pkg.sv
// Shared types for the execute/memory back end: condition codes, flag indices,
// flag-write select.
package cpu_pkg;

   typedef enum logic [3:0] {
      EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
      MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
      HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
      GT = 4'hC, LE = 4'hD, AL = 4'hE
   } cond_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // nz selects the N,Z pair, cv selects the C,V pair
   typedef struct packed {
      logic nz;
      logic cv;
   } flagwrite_t;

endpackage

// File: rtl/cond_check.sv
// Pure combinational ARM condition evaluator; reusable by any predicated stage.
module cond_check
   import cpu_pkg::*;
(
   input  logic [3:0] CondE,
   input  logic [3:0] Flags,
   output logic       CondExE
);

   logic n, z, c, v;
   assign n = Flags[FLAG_N];
   assign z = Flags[FLAG_Z];
   assign c = Flags[FLAG_C];
   assign v = Flags[FLAG_V];

   // Decode the condition field against the current flags; 4'hF behaves as AL
   always_comb begin
      CondExE = 1'b1;
      case (cond_t'(CondE))
         EQ: CondExE = z;
         NE: CondExE = ~z;
         CS: CondExE = c;
         CC: CondExE = ~c;
         MI: CondExE = n;
         PL: CondExE = ~n;
         VS: CondExE = v;
         VC: CondExE = ~v;
         HI: CondExE = c & ~z;
         LS: CondExE = ~c | z;
         GE: CondExE = (n == v);
         LT: CondExE = (n != v);
         GT: CondExE = ~z & (n == v);
         LE: CondExE = z | (n != v);
         default: CondExE = 1'b1;
      endcase
   end

endmodule

// File: rtl/cond_exec_stage.sv
// Execute-stage back end: NZCV flags register, condition gating of write
// enables, and the E->M pipeline register.
module cond_exec_stage
   import cpu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int RA_BITS = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               StallM,
   input  logic               FlushE,
   input  logic [3:0]         CondE,
   input  logic [1:0]         FlagWriteE,
   input  logic [3:0]         ALUFlags,
   input  logic [WIDTH-1:0]   ALUResultE,
   input  logic [WIDTH-1:0]   WriteDataE,
   input  logic [RA_BITS-1:0] WA3E,
   input  logic               RegWriteE,
   input  logic               MemWriteE,
   input  logic               MemtoRegE,
   input  logic               PCSrcE,
   input  logic               BranchE,
   output logic               CondExE,
   output logic               BranchTakenE,
   output logic [3:0]         Flags,
   output logic [WIDTH-1:0]   ALUResultM,
   output logic [WIDTH-1:0]   WriteDataM,
   output logic [RA_BITS-1:0] WA3M,
   output logic               RegWriteM,
   output logic               MemWriteM,
   output logic               MemtoRegM,
   output logic               PCSrcM
);

   flagwrite_t fw;
   assign fw = flagwrite_t'(FlagWriteE);

   // Condition is evaluated on the registered flags only; no bypass from ALUFlags
   cond_check u_cond (
      .CondE   (CondE),
      .Flags   (Flags),
      .CondExE (CondExE)
   );

   assign BranchTakenE = BranchE & CondExE & ~FlushE;

   // Flags register: stall freezes, flush or a failed condition suppresses the write
   always_ff @(posedge clk) begin
      if (!reset) begin
         Flags <= '0;
      end else if (!StallM && !FlushE && CondExE) begin
         if (fw.nz) begin
            Flags[FLAG_N] <= ALUFlags[FLAG_N];
            Flags[FLAG_Z] <= ALUFlags[FLAG_Z];
         end
         if (fw.cv) begin
            Flags[FLAG_C] <= ALUFlags[FLAG_C];
            Flags[FLAG_V] <= ALUFlags[FLAG_V];
         end
      end
   end

   // E->M register: stall holds, flush inserts a bubble, else load gated control
   always_ff @(posedge clk) begin
      if (!reset) begin
         ALUResultM <= '0;
         WriteDataM <= '0;
         WA3M       <= '0;
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         MemtoRegM  <= 1'b0;
         PCSrcM     <= 1'b0;
      end else if (!StallM) begin
         if (FlushE) begin
            ALUResultM <= '0;
            WriteDataM <= '0;
            WA3M       <= '0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            PCSrcM     <= 1'b0;
         end else begin
            ALUResultM <= ALUResultE;
            WriteDataM <= WriteDataE;
            WA3M       <= WA3E;
            RegWriteM  <= RegWriteE & CondExE;
            MemWriteM  <= MemWriteE & CondExE;
            MemtoRegM  <= MemtoRegE;
            PCSrcM     <= PCSrcE & CondExE;
         end
      end
   end

endmodule
